// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = A - B - bin, one bit per clock, LSB first.
// Operands load on an accepted start; diff/bout/ovf are valid while done pulses.
module serial_subtractor #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] A,
   input  logic [WIDTH-1:0] B,
   input  logic             bin,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf
);

   typedef enum logic [1:0] {
      StIdle,
      StShift,
      StDone
   } state_e;

   state_e state_q, state_d;

   logic [WIDTH-1:0] a_sr_q, a_sr_d;
   logic [WIDTH-1:0] b_sr_q, b_sr_d;
   logic [WIDTH-1:0] diff_q, diff_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             br_q, br_d;
   logic             bout_q, bout_d;
   logic             ovf_q, ovf_d;
   // Captured operand sign bits {A_msb, B_msb}; the shift registers lose them.
   logic [1:0]       msb_q, msb_d;

   logic a_bit, b_bit, d_bit, br_next, last_bit, accept;

   assign a_bit    = a_sr_q[0];
   assign b_bit    = b_sr_q[0];
   assign d_bit    = a_bit ^ b_bit ^ br_q;
   assign br_next  = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & br_q);
   assign last_bit = (cnt_q == CNT_W'(WIDTH - 1));
   assign accept   = (state_q == StIdle) && start;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               state_d = StShift;
            end
         end
         StShift: begin
            if (last_bit) begin
               state_d = StDone;
            end
         end
         StDone: begin
            state_d = StIdle;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   // Outputs decoded from state
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      unique case (state_q)
         StShift: busy = 1'b1;
         StDone:  done = 1'b1;
         default: ;
      endcase
   end

   // Datapath next-state
   always_comb begin
      a_sr_d = a_sr_q;
      b_sr_d = b_sr_q;
      diff_d = diff_q;
      cnt_d  = cnt_q;
      br_d   = br_q;
      bout_d = bout_q;
      ovf_d  = ovf_q;
      msb_d  = msb_q;
      if (accept) begin
         a_sr_d = A;
         b_sr_d = B;
         br_d   = bin;
         cnt_d  = '0;
         msb_d  = {A[WIDTH-1], B[WIDTH-1]};
      end else if (state_q == StShift) begin
         a_sr_d = {1'b0, a_sr_q[WIDTH-1:1]};
         b_sr_d = {1'b0, b_sr_q[WIDTH-1:1]};
         diff_d = {d_bit, diff_q[WIDTH-1:1]};
         br_d   = br_next;
         cnt_d  = cnt_q + CNT_W'(1);
         if (last_bit) begin
            bout_d = br_next;
            // Operand signs differ and the result sign disagrees with the minuend.
            ovf_d  = (msb_q[1] ^ msb_q[0]) & (d_bit ^ msb_q[1]);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_sr_q <= '0;
         b_sr_q <= '0;
         diff_q <= '0;
         cnt_q  <= '0;
         br_q   <= 1'b0;
         bout_q <= 1'b0;
         ovf_q  <= 1'b0;
         msb_q  <= '0;
      end else begin
         a_sr_q <= a_sr_d;
         b_sr_q <= b_sr_d;
         diff_q <= diff_d;
         cnt_q  <= cnt_d;
         br_q   <= br_d;
         bout_q <= bout_d;
         ovf_q  <= ovf_d;
         msb_q  <= msb_d;
      end
   end

   assign diff = diff_q;
   assign bout = bout_q;
   assign ovf  = ovf_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Scoreboard bench for serial_subtractor: stimulus pushes model results, a monitor pops on done.
module tb_serial_subtractor;

   localparam int unsigned W = 32;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic [W-1:0] a = '0;
   logic [W-1:0] b = '0;
   logic         bin = 1'b0;
   logic         busy, done, bout, ovf;
   logic [W-1:0] diff;

   typedef struct {
      logic [W-1:0] diff;
      logic         bout;
      logic         ovf;
      longint       due;
   } exp_t;

   exp_t   sb[$];
   exp_t   last_exp;
   longint cyc = 0;
   int     busy_cnt = 0;
   int     checks = 0;
   int     failures = 0;

   serial_subtractor #(.WIDTH(W)) dut (
      .clk  (clk),
      .rst  (rst),
      .start(start),
      .A    (a),
      .B    (b),
      .bin  (bin),
      .busy (busy),
      .done (done),
      .diff (diff),
      .bout (bout),
      .ovf  (ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
      end
   endtask

   // Reference: plain wide unsigned and signed arithmetic.
   function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi);
      exp_t          e;
      logic [W:0]    full;
      longint        s;
      full   = {1'b0, x} - {1'b0, y} - {{W{1'b0}}, bi};
      e.diff = full[W-1:0];
      e.bout = full[W];
      s      = longint'($signed(x)) - longint'($signed(y)) - longint'(bi);
      e.ovf  = (s > 64'sd2147483647) || (s < -64'sd2147483648);
      e.due  = 0;
      return e;
   endfunction

   // Called at a negedge when the DUT will be idle at the next posedge.
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y, input logic bi,
                         input int gap);
      exp_t e;
      a     = x;
      b     = y;
      bin   = bi;
      start = 1'b1;
      e     = model(x, y, bi);
      e.due = cyc + 1 + W;
      sb.push_back(e);
      // Keep poking start and operands while busy/done; all must be ignored.
      repeat (W + 1) begin
         @(negedge clk);
         start = 1'($urandom_range(0, 1));
         a     = $urandom;
         b     = $urandom;
         bin   = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      start = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   // Monitor
   initial begin
      last_exp = '{diff: '0, bout: 1'b0, ovf: 1'b0, due: 0};
      forever begin
         @(negedge clk);
         if (rst) begin
            busy_cnt = 0;
            last_exp = '{diff: '0, bout: 1'b0, ovf: 1'b0, due: 0};
         end else begin
            if (busy) busy_cnt++;
            if (done) begin
               if (sb.size() == 0) begin
                  checks++;
                  failures++;
                  $display("FAIL unexpected_done: got done=1 expected no pending op (cycle %0d)",
                           cyc);
               end else begin
                  last_exp = sb.pop_front();
                  chk("diff", 64'(diff), 64'(last_exp.diff));
                  chk("bout", 64'(bout), 64'(last_exp.bout));
                  chk("ovf", 64'(ovf), 64'(last_exp.ovf));
                  chk("latency", 64'(cyc), 64'(last_exp.due));
                  chk("busy_cycles", 64'(busy_cnt), 64'(W));
                  chk("busy_in_done", 64'(busy), 64'(0));
               end
               busy_cnt = 0;
            end else if (!busy) begin
               chk("hold_diff", 64'(diff), 64'(last_exp.diff));
               chk("hold_flags", 64'({bout, ovf}), 64'({last_exp.bout, last_exp.ovf}));
            end
         end
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   // Stimulus
   initial begin
      repeat (3) @(negedge clk);
      chk("rst_busy", 64'(busy), 64'(0));
      chk("rst_done", 64'(done), 64'(0));
      chk("rst_diff", 64'(diff), 64'(0));
      chk("rst_bout_ovf", 64'({bout, ovf}), 64'(0));
      rst = 1'b0;
      @(negedge clk);

      run_op(32'd5, 32'd3, 1'b0, 1);
      run_op(32'd3, 32'd5, 1'b0, 0);
      run_op(32'h8000_0000, 32'h0, 1'b1, 2);
      run_op(32'h0, 32'h0, 1'b1, 0);
      run_op(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);

      // Reset in the tenth SHIFT cycle, with a nonzero partial diff and bout=1 held.
      a     = 32'hFFFF_FFFF;
      b     = 32'h0;
      bin   = 1'b0;
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (9) @(negedge clk);
      #2 rst = 1'b1;
      #1;
      chk("async_rst_busy", 64'(busy), 64'(0));
      chk("async_rst_done", 64'(done), 64'(0));
      chk("async_rst_diff", 64'(diff), 64'(0));
      chk("async_rst_flags", 64'({bout, ovf}), 64'(0));
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (40) @(negedge clk);
      run_op(32'd100, 32'd1, 1'b0, 1);

      for (int i = 0; i < 1000; i++) begin
         run_op($urandom, $urandom, 1'($urandom_range(0, 1)),
                ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 3)) : 0);
      end

      repeat (W + 5) @(negedge clk);
      chk("pending_ops", 64'(sb.size()), 64'(0));
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
- Bit-serial WIDTH-bit subtractor. Computes diff = A - B - bin one bit per clock, LSB first.
- Uses a single registered borrow flip-flop.
- Companion to the serial adder datapath: it is the inverse arithmetic direction and reuses the same load/shift/done sequencing.
- Parallel operands are loaded on start. The parallel result, borrow-out and signed overflow are presented when done.

Parameters:
- WIDTH, 32, operand/result width in bits (legal values: 2 or more).
- CNT_W, $clog2(WIDTH+1), bit-counter width (derived, not for override).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- A  input  WIDTH  minuend, captured on accepted start.
- B  input  WIDTH  subtrahend, captured on accepted start.
- bin  input  1  borrow-in, captured on accepted start.
- busy  output  1  high while in SHIFT.
- done  output  1  one-cycle pulse in DONE; results valid.
- diff  output  WIDTH  difference; held until next accepted start.
- bout  output  1  final borrow-out; 1 when A < B + bin (unsigned).
- ovf  output  1  signed overflow of A - B - bin.

Behaviour:
- Reset (async, rst=1) clears everything immediately:
  - state=IDLE; busy=0, done=0, diff=0, bout=0, ovf=0.
  - Shift registers, borrow FF and counter = 0.
  - Applies at any time, including mid-SHIFT; the in-flight operation is discarded and no done is issued.
- States: IDLE, SHIFT, DONE (registered FSM; busy/done decoded from state).
- IDLE:
  - start=1 at an edge: load a_sr<=A, b_sr<=B, br<=bin, cnt<=0, state<=SHIFT.
  - start=0: stay in IDLE; diff/bout/ovf hold their previous values.
- SHIFT, every edge:
  - Bit ops on a=a_sr[0], b=b_sr[0]:
    - d = a ^ b ^ br.
    - br <= (~a & b) | (~(a ^ b) & br).
  - Shift a_sr and b_sr right by 1.
  - diff <= {d, diff[WIDTH-1:1]}.
  - cnt <= cnt+1.
  - On the edge where cnt==WIDTH-1 (last bit):
    - bout <= new borrow.
    - ovf <= (A_msb ^ B_msb) & (d ^ A_msb), using captured operand MSBs held in a dedicated register.
    - state <= DONE.
- DONE: lasts exactly one cycle with done=1, then state <= IDLE.
- Latency: start accepted at edge E0; SHIFT occupies edges E1..E_WIDTH; done=1 in the cycle after E_WIDTH. That is WIDTH+1 cycles from acceptance to done; the next start is accepted no earlier than edge E_WIDTH+2.
- start while busy or in DONE: ignored, with no effect on operands or results.
- During SHIFT, diff is partially shifted and not valid; consumers use done.
- A/B/bin changes after acceptance have no effect.
- Arithmetic is modulo 2^WIDTH: diff == (A - B - bin) mod 2^WIDTH; bout is the unsigned borrow out of the MSB.

Test Plan:
- Basic subtraction: WIDTH=32, A=5, B=3, bin=0, start pulse -> done exactly 33 cycles after acceptance; diff=0x00000002, bout=0, ovf=0; busy high for 32 cycles.
- Negative result: A=3, B=5, bin=0 -> diff=0xFFFFFFFE, bout=1, ovf=0.
- Borrow-in and overflow:
  - A=0x80000000, B=0x00000000, bin=1 -> diff=0x7FFFFFFF, bout=0, ovf=1.
  - A=0, B=0, bin=1 -> diff=0xFFFFFFFF, bout=1, ovf=0.
- Start rejection: assert start continuously and change A/B mid-operation -> exactly one operation per IDLE visit, results reflect the operands captured at acceptance, done pulses once per op.
- Reset mid-operation: assert rst at SHIFT cycle 10 -> outputs 0 immediately (asynchronously), no done pulse; a new op A=100, B=1 then gives diff=99.
- Randomized back-to-back: 1000 random A/B/bin against a reference model -> diff/bout/ovf match on every done; results hold stable between done and the next start.
